// File: rtl/alu_uart_frame_ctrl_if.sv
// alu_uart_frame_ctrl_if
//   Bundles the UART FIFO handshake and the ALU operand/result bus that
//   surround the frame controller.
//   master modport: the frame controller (pops RX, pushes TX, drives ALU inputs)
//   slave modport : the environment (RX/TX FIFOs and the ALU)
//   Signals:
//     r_data   RX FIFO head byte (first-word-fall-through)
//     rx_empty RX FIFO empty flag
//     rd_uart  RX pop strobe
//     w_data   TX FIFO write byte
//     tx_full  TX FIFO full flag
//     wr_uart  TX push strobe
//     op_code  ALU opcode
//     data_a   ALU operand A
//     data_b   ALU operand B
//     result   ALU result, combinational from op_code/data_a/data_b
interface alu_uart_frame_ctrl_if #(
  parameter int DBIT   = 8,
  parameter int NB_OP  = 6,
  parameter int NB_AB  = 16,
  parameter int NB_RES = 16
);
  logic [DBIT-1:0]   r_data;
  logic              rx_empty;
  logic              rd_uart;
  logic [DBIT-1:0]   w_data;
  logic              tx_full;
  logic              wr_uart;
  logic [NB_OP-1:0]  op_code;
  logic [NB_AB-1:0]  data_a;
  logic [NB_AB-1:0]  data_b;
  logic [NB_RES-1:0] result;

  modport master (
    input  r_data, rx_empty, tx_full, result,
    output rd_uart, w_data, wr_uart, op_code, data_a, data_b
  );

  modport slave (
    output r_data, rx_empty, tx_full, result,
    input  rd_uart, w_data, wr_uart, op_code, data_a, data_b
  );
endinterface

// File: rtl/alu_uart_frame_ctrl.sv
// alu_uart_frame_ctrl
//   Frame controller between the UART RX/TX FIFOs and an ALU. Receives an
//   opcode byte followed by operands A and B (LSB byte first), commits them to
//   the ALU in a single cycle, captures the result one cycle later and streams
//   it to the TX FIFO LSB byte first, honouring tx_full back-pressure.
//   An inter-byte idle timeout inside a frame aborts the frame.
//   Ports:
//     clk         system clock
//     reset       asynchronous, active-high reset
//     bus         FIFO + ALU bundle (master side)
//     busy        high whenever a frame is in progress
//     timeout_err one-cycle pulse when a frame is aborted by the timeout
//     frame_cnt   completed frames, wraps modulo 2^NB_CNT
module alu_uart_frame_ctrl #(
  parameter int DBIT        = 8,
  parameter int NB_OP       = 6,
  parameter int NB_AB       = 16,
  parameter int NB_RES      = 16,
  parameter int TIMEOUT_CYC = 100000,
  parameter int NB_CNT      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_uart_frame_ctrl_if.master bus,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [NB_CNT-1:0]     frame_cnt
);

  localparam int NBY_AB   = NB_AB / DBIT;
  localparam int NBY_RES  = NB_RES / DBIT;
  localparam int NBY_MAX  = (NBY_AB > NBY_RES) ? NBY_AB : NBY_RES;
  localparam int CW       = (NBY_MAX > 1) ? $clog2(NBY_MAX) : 1;
  localparam int TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  localparam logic [CW-1:0] AB_LAST  = CW'(NBY_AB - 1);
  localparam logic [CW-1:0] RES_LAST = CW'(NBY_RES - 1);
  localparam logic [TW-1:0] TMO_END  = TW'(TMO_LAST);

  typedef enum logic [2:0] {RX_OP, RX_A, RX_B, COMMIT, EXEC, TX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               rd_q, rd_d;
  logic               tmo_err_q, tmo_err_d;
  logic [NB_OP-1:0]   op_sh_q, op_sh_d;
  logic [NB_AB-1:0]   a_sh_q, a_sh_d;
  logic [NB_AB-1:0]   b_sh_q, b_sh_d;
  logic [NB_RES-1:0]  res_q, res_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_AB-1:0]   a_q, a_d;
  logic [NB_AB-1:0]   b_q, b_d;
  logic [NB_CNT-1:0]  frame_cnt_q, frame_cnt_d;
  logic               wr_s;
  logic [DBIT-1:0]    w_data_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RX_OP;
      cnt_q       <= '0;
      tmo_q       <= '0;
      rd_q        <= 1'b0;
      tmo_err_q   <= 1'b0;
      op_sh_q     <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      rd_q        <= rd_d;
      tmo_err_q   <= tmo_err_d;
      op_sh_q     <= op_sh_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    tmo_err_d   = 1'b0;
    op_sh_d     = op_sh_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    frame_cnt_d = frame_cnt_q;
    wr_s        = 1'b0;
    w_data_s    = '0;

    case (state_q)
      RX_OP: begin
        if (rd_q) begin
          op_sh_d = bus.r_data[NB_OP-1:0];
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = RX_A;
        end
      end

      RX_A, RX_B: begin
        // A pop always wins over the timeout and restarts the idle count.
        if (rd_q) begin
          if (state_q == RX_A) a_sh_d[32'(cnt_q)*DBIT +: DBIT] = bus.r_data;
          else                 b_sh_d[32'(cnt_q)*DBIT +: DBIT] = bus.r_data;
          tmo_d = '0;
          if (cnt_q == AB_LAST) begin
            cnt_d   = '0;
            state_d = (state_q == RX_A) ? RX_B : COMMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if ((TIMEOUT_CYC != 0) && bus.rx_empty) begin
          if (tmo_q == TMO_END) begin
            tmo_d     = '0;
            tmo_err_d = 1'b1;
            cnt_d     = '0;
            op_sh_d   = '0;
            a_sh_d    = '0;
            b_sh_d    = '0;
            state_d   = RX_OP;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      // The only place the ALU inputs ever change.
      COMMIT: begin
        op_d    = op_sh_q;
        a_d     = a_sh_q;
        b_d     = b_sh_q;
        state_d = EXEC;
      end

      EXEC: begin
        res_d   = bus.result;
        state_d = TX;
      end

      TX: begin
        w_data_s = res_q[32'(cnt_q)*DBIT +: DBIT];
        if (!bus.tx_full) begin
          wr_s = 1'b1;
          if (cnt_q == RES_LAST) begin
            cnt_d       = '0;
            frame_cnt_d = frame_cnt_q + 1'b1;
            state_d     = RX_OP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = RX_OP;
    endcase

    // The pop strobe is registered, so the decision looks at where the FSM
    // will be next cycle; this lets RX_OP pop right after the final TX push.
    // Skipping the cycle of an active pop keeps pops at most one per two
    // cycles, giving the FIFO time to update rx_empty.
    rd_d = !rd_q && !bus.rx_empty && (state_d inside {RX_OP, RX_A, RX_B});
  end

  assign bus.rd_uart = rd_q;
  assign bus.wr_uart = wr_s;
  assign bus.w_data  = w_data_s;
  assign bus.op_code = op_q;
  assign bus.data_a  = a_q;
  assign bus.data_b  = b_q;
  assign busy        = (state_q != RX_OP) || (cnt_q != '0);
  assign timeout_err = tmo_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_alu_uart_frame_ctrl.sv
// tb_alu_uart_frame_ctrl
//   Drives byte frames into a modelled RX FIFO, provides a combinational ALU,
//   and checks TX bytes, committed ALU inputs and frame counts against
//   expected frame records queued when each frame is issued.
module tb_alu_uart_frame_ctrl;

  localparam int DBIT    = 8;
  localparam int NB_OP   = 6;
  localparam int NB_AB   = 16;
  localparam int NB_RES  = 16;
  localparam int TMO     = 50;
  localparam int NB_CNT  = 2;
  localparam int NBY_RES = NB_RES / DBIT;

  typedef struct {
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [1:0]  fc;
  } rec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              busy;
  logic              timeout_err;
  logic [NB_CNT-1:0] frame_cnt;

  int   nTests = 0;
  int   nFail = 0;
  int   fcModel = 0;
  int   rdCount = 0;
  int   wrCount = 0;
  int   tmoSeen = 0;
  int   popsInFrame = 0;
  int   monJ = 0;
  bit   monPend = 1'b0;
  bit   txRandom = 1'b0;
  rec_t monCur;
  rec_t expQ[$];
  logic [7:0] rxQ[$];

  always #5 clk = ~clk;

  alu_uart_frame_ctrl_if #(.DBIT(DBIT), .NB_OP(NB_OP), .NB_AB(NB_AB), .NB_RES(NB_RES)) bus ();

  alu_uart_frame_ctrl #(
    .DBIT(DBIT), .NB_OP(NB_OP), .NB_AB(NB_AB), .NB_RES(NB_RES),
    .TIMEOUT_CYC(TMO), .NB_CNT(NB_CNT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .timeout_err(timeout_err),
    .frame_cnt(frame_cnt)
  );

  // Bench ALU, MIPS-style function codes.
  function automatic logic [15:0] aluRef(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      6'h20:   return 16'((int'(a) + int'(b)) % 65536);
      6'h22:   return 16'((int'(a) - int'(b) + 65536) % 65536);
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 16'h0000;
    endcase
  endfunction

  always_comb bus.result = aluRef(bus.op_code, bus.data_a, bus.data_b);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refreshRx();
    bus.rx_empty = (rxQ.size() == 0);
    bus.r_data   = (rxQ.size() == 0) ? 8'h00 : rxQ[0];
  endtask

  // One clock: note the pop strobe before the edge, retire the head after it.
  task automatic tick();
    logic pop;
    logic [7:0] junk;
    @(negedge clk);
    pop = bus.rd_uart;
    @(posedge clk);
    #1;
    if (pop && rxQ.size() > 0) junk = rxQ.pop_front();
    if (txRandom) bus.tx_full = ($urandom_range(0, 3) == 0);
    refreshRx();
  endtask

  task automatic pushByte(input logic [7:0] b);
    rxQ.push_back(b);
    refreshRx();
  endtask

  // Queue the expected outcome of one complete frame, then feed its bytes.
  task automatic applyStimulus(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b, input int gap);
    rec_t r;
    logic [7:0] bytes [5];
    r.op    = 6'(opb % 64);
    r.a     = a;
    r.b     = b;
    r.res   = aluRef(r.op, a, b);
    fcModel = (fcModel + 1) % 4;
    r.fc    = 2'(fcModel);
    expQ.push_back(r);
    bytes[0] = opb;
    bytes[1] = 8'(a % 256);
    bytes[2] = 8'(a / 256);
    bytes[3] = 8'(b % 256);
    bytes[4] = 8'(b / 256);
    for (int i = 0; i < 5; i++) begin
      pushByte(bytes[i]);
      repeat (gap) tick();
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || rxQ.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL wait_idle: still %0d frames pending after %0d cycles, expected 0", expQ.size(), n);
    end
    repeat (3) tick();
  endtask

  task automatic waitRxDrained(input int budget);
    int n = 0;
    while (rxQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL rx_drain: %0d bytes left after %0d cycles, expected 0", rxQ.size(), n);
    end
  endtask

  task automatic assertReset();
    reset = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_rd_uart", bus.rd_uart, 0);
    checkOutput("rst_wr_uart", bus.wr_uart, 0);
    checkOutput("rst_w_data", bus.w_data, 0);
    checkOutput("rst_op_code", bus.op_code, 0);
    checkOutput("rst_data_a", bus.data_a, 0);
    checkOutput("rst_data_b", bus.data_b, 0);
    expQ.delete();
    fcModel = 0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Monitor: pops expected frame records as the DUT pushes TX bytes.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        monJ = 0;
        monPend = 1'b0;
        popsInFrame = 0;
      end else begin
        if (monPend) begin
          checkOutput("frame_cnt", frame_cnt, monCur.fc);
          monPend = 1'b0;
        end
        if (timeout_err) begin
          tmoSeen++;
          popsInFrame = 0;
        end
        if (bus.rd_uart) begin
          rdCount++;
          checkOutput("rd_while_empty", bus.rx_empty, 0);
          checkOutput("pop_during_exec_tx", (popsInFrame >= 5), 0);
          popsInFrame++;
        end
        if (bus.wr_uart) begin
          wrCount++;
          checkOutput("wr_while_full", bus.tx_full, 0);
          if (monJ == 0) begin
            if (expQ.size() == 0) begin
              nTests++;
              nFail++;
              $display("[TB] FAIL unexpected_tx: got byte %0h, expected no push", bus.w_data);
            end else begin
              monCur = expQ.pop_front();
              checkOutput("commit_op_code", bus.op_code, monCur.op);
              checkOutput("commit_data_a", bus.data_a, monCur.a);
              checkOutput("commit_data_b", bus.data_b, monCur.b);
            end
          end
          checkOutput("tx_byte", bus.w_data, 32'((monCur.res >> (8 * monJ)) & 16'h00FF));
          monJ++;
          if (monJ == NBY_RES) begin
            monJ = 0;
            monPend = 1'b1;
            popsInFrame = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, w0, t0;
    logic [7:0] opb;
    logic [5:0] ops [7];
    ops[0] = 6'h20; ops[1] = 6'h22; ops[2] = 6'h24; ops[3] = 6'h25;
    ops[4] = 6'h26; ops[5] = 6'h27; ops[6] = 6'h01;

    bus.tx_full = 1'b0;
    refreshRx();
    #2;
    assertReset();

    // Basic add frame.
    r0 = rdCount; w0 = wrCount;
    applyStimulus(8'h20, 16'h1234, 16'h0001, 0);
    waitIdle(200);
    checkOutput("basic_rd_pulses", rdCount - r0, 5);
    checkOutput("basic_wr_pulses", wrCount - w0, 2);
    checkOutput("basic_frame_cnt", frame_cnt, 1);

    // Opcode upper bits dropped.
    applyStimulus(8'hE0, 16'h00FF, 16'h0001, 1);
    waitIdle(200);

    // TX back-pressure at TX entry.
    bus.tx_full = 1'b1;
    w0 = wrCount;
    applyStimulus(8'h20, 16'h1234, 16'h0001, 0);
    waitRxDrained(100);
    repeat (3) tick();
    checkOutput("busy_while_full", busy, 1);
    repeat (10) tick();
    checkOutput("no_push_while_full", wrCount - w0, 0);
    bus.tx_full = 1'b0;
    waitIdle(200);
    checkOutput("push_count_after_full", wrCount - w0, 2);

    // Randomised frames with gaps and random back-pressure.
    t0 = tmoSeen;
    txRandom = 1'b1;
    for (int i = 0; i < 20; i++) begin
      opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 6)]};
      applyStimulus(opb, 16'($urandom), 16'($urandom), (i % 4 == 3) ? 0 : $urandom_range(0, 6));
      if (i % 4 != 2) waitIdle(400);
    end
    waitIdle(2000);
    txRandom = 1'b0;
    bus.tx_full = 1'b0;
    checkOutput("random_no_timeout", tmoSeen - t0, 0);

    // Inter-byte timeout.
    assertReset();
    t0 = tmoSeen;
    pushByte(8'h20);
    pushByte(8'h34);
    repeat (40) tick();
    checkOutput("no_early_timeout", tmoSeen - t0, 0);
    checkOutput("busy_during_stall", busy, 1);
    repeat (30) tick();
    checkOutput("timeout_pulses", tmoSeen - t0, 1);
    checkOutput("busy_after_timeout", busy, 0);
    checkOutput("data_a_kept", bus.data_a, 0);
    checkOutput("frame_cnt_after_timeout", frame_cnt, 0);
    applyStimulus(8'h20, 16'h0002, 16'h0003, 2);
    waitIdle(200);

    // Reset in the middle of operand B.
    pushByte(8'h20); pushByte(8'hFF); pushByte(8'hFF); pushByte(8'h01);
    waitRxDrained(100);
    tick();
    checkOutput("busy_mid_frame", busy, 1);
    assertReset();
    applyStimulus(8'h20, 16'hFFFF, 16'h0001, 0);
    waitIdle(200);
    checkOutput("post_reset_frame_cnt", frame_cnt, 1);

    // Preloaded back-to-back frames and counter wrap.
    assertReset();
    applyStimulus(8'h22, 16'h0100, 16'h0001, 0);
    applyStimulus(8'h26, 16'hA5A5, 16'h0FF0, 0);
    waitIdle(300);
    checkOutput("two_frames_cnt", frame_cnt, 2);
    for (int i = 0; i < 3; i++) applyStimulus(8'h25, 16'($urandom), 16'($urandom), 0);
    waitIdle(500);
    checkOutput("wrap_frame_cnt", frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
